johnson_decoder_checker_8_bit: RTL and testbench

Receive-side companion to the team's 8-bit Johnson counter. Samples a WIDTH-bit Johnson code word, decodes it to a binary phase index (0..2*WIDTH-1) and flags illegal patterns. It tracks step-to-step sequencing and locks after a run of correct steps. Once locked, it reports and counts sequencing errors. Sits downstream of any Johnson-coded phase or state bus, as a decoder and integrity monitor.

---
 rtl/johnson_decoder_checker_8_bit.sv | 160 ++++++++++++++++
 tb/tb_johnson_decoder_checker_8_bit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder_checker_8_bit.sv
// rtl/johnson_decoder_checker_8_bit.sv - Johnson code decoder with sequencing lock and error monitor
module johnson_decoder_checker_8_bit #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic                          Sample_En_In,
  input  logic [WIDTH-1:0]              Code_In,
  input  logic                          Expect_Step_In,
  input  logic                          Clear_Errors_In,
  output logic [$clog2(2*WIDTH)-1:0]    Index_Out,
  output logic                          Valid_Code_Out,
  output logic                          Locked_Out,
  output logic                          Step_Error_Out,
  output logic [ERR_CNT_W-1:0]          Error_Count_Out
);

  localparam int                   IDX_W     = $clog2(2*WIDTH);
  localparam logic [WIDTH-1:0]     ONES      = '1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(2*WIDTH-1);
  localparam logic [3:0]           LOCK_GOOD = 4'(LOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             good_q, good_d;
  logic [IDX_W-1:0]       index_q, index_d;
  logic                   valid_q, valid_d;
  logic                   step_err_q, step_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   dec_valid;
  logic [IDX_W-1:0]       dec_index;
  logic [IDX_W-1:0]       exp_index;
  logic                   match;
  logic [3:0]             good_inc;

  // Decode the word: ones filling from the MSB give 0..W, zeros filling from the MSB give W+1..2W-1
  always_comb begin
    dec_valid = 1'b0;
    dec_index = '0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (Code_In == ~(ONES >> k)) begin
        dec_valid = 1'b1;
        dec_index = IDX_W'(k);
      end
    end
    for (int j = 1; j < WIDTH; j++) begin
      if (Code_In == (ONES >> j)) begin
        dec_valid = 1'b1;
        dec_index = IDX_W'(WIDTH + j);
      end
    end
  end

  // Expected index is the held index plus the requested step, wrapping at 2*WIDTH
  always_comb begin
    exp_index = '0;
    if (!(Expect_Step_In && (index_q == LAST_IDX))) begin
      exp_index = index_q + {{(IDX_W-1){1'b0}}, Expect_Step_In};
    end
    match    = dec_valid && (dec_index == exp_index);
    good_inc = good_q + 4'd1;
  end

  // Sequencing FSM and output updates; nothing moves unless a sample is taken
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    index_d    = index_q;
    valid_d    = valid_q;
    step_err_d = 1'b0;
    if (Sample_En_In) begin
      valid_d = dec_valid;
      if (dec_valid) begin
        index_d = dec_index;
      end
      case (state_q)
        HUNT: begin
          if (dec_valid) begin
            state_d = CHECK;
            good_d  = 4'd1;
          end
        end
        CHECK: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc >= LOCK_GOOD) begin
              state_d = LOCKED;
            end
          end else if (dec_valid) begin
            good_d = 4'd1;
          end else begin
            state_d = HUNT;
            good_d  = 4'd0;
          end
        end
        LOCKED: begin
          if (!match) begin
            step_err_d = 1'b1;
            if (dec_valid) begin
              state_d = CHECK;
              good_d  = 4'd1;
            end else begin
              state_d = HUNT;
              good_d  = 4'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          good_d  = 4'd0;
        end
      endcase
    end
  end

  // Saturating error counter; clear overrides a coincident increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (Clear_Errors_In) begin
      err_cnt_d = '0;
    end else if (step_err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q    <= HUNT;
      good_q     <= 4'd0;
      index_q    <= '0;
      valid_q    <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      index_q    <= index_d;
      valid_q    <= valid_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign Index_Out       = index_q;
  assign Valid_Code_Out  = valid_q;
  assign Locked_Out      = (state_q == LOCKED);
  assign Step_Error_Out  = step_err_q;
  assign Error_Count_Out = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder_checker_8_bit.sv
// tb/tb_johnson_decoder_checker_8_bit.sv - directed self-checking bench for the Johnson decoder/checker
module tb_johnson_decoder_checker_8_bit;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic [7:0] code;
  logic       step;
  logic       clr;

  logic [3:0] idx_a, idx_b;
  logic       valid_a, valid_b;
  logic       lock_a, lock_b;
  logic       err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;
  int p;
  logic [7:0] jc [16];

  johnson_decoder_checker_8_bit u_dut (
    .Clk_In          (clk),
    .Reset_In        (rst),
    .Sample_En_In    (sample_en),
    .Code_In         (code),
    .Expect_Step_In  (step),
    .Clear_Errors_In (clr),
    .Index_Out       (idx_a),
    .Valid_Code_Out  (valid_a),
    .Locked_Out      (lock_a),
    .Step_Error_Out  (err_a),
    .Error_Count_Out (cnt_a)
  );

  johnson_decoder_checker_8_bit #(.ERR_CNT_W(2)) u_sat (
    .Clk_In          (clk),
    .Reset_In        (rst),
    .Sample_En_In    (sample_en),
    .Code_In         (code),
    .Expect_Step_In  (step),
    .Clear_Errors_In (clr),
    .Index_Out       (idx_b),
    .Valid_Code_Out  (valid_b),
    .Locked_Out      (lock_b),
    .Step_Error_Out  (err_b),
    .Error_Count_Out (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_idx, input int e_v, input int e_l,
                         input int e_e, input int e_c);
    chk({tag, "_idx"},   32'(idx_a),   32'(e_idx));
    chk({tag, "_valid"}, 32'(valid_a), 32'(e_v));
    chk({tag, "_lock"},  32'(lock_a),  32'(e_l));
    chk({tag, "_err"},   32'(err_a),   32'(e_e));
    chk({tag, "_cnt"},   32'(cnt_a),   32'(e_c));
  endtask

  task automatic samp(input logic [7:0] c, input logic s);
    @(negedge clk);
    sample_en = 1'b1;
    code      = c;
    step      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] c);
    @(negedge clk);
    sample_en = 1'b0;
    code      = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    jc[0]  = 8'b00000000; jc[1]  = 8'b10000000; jc[2]  = 8'b11000000; jc[3]  = 8'b11100000;
    jc[4]  = 8'b11110000; jc[5]  = 8'b11111000; jc[6]  = 8'b11111100; jc[7]  = 8'b11111110;
    jc[8]  = 8'b11111111; jc[9]  = 8'b01111111; jc[10] = 8'b00111111; jc[11] = 8'b00011111;
    jc[12] = 8'b00001111; jc[13] = 8'b00000111; jc[14] = 8'b00000011; jc[15] = 8'b00000001;

    rst = 1'b1; sample_en = 1'b0; code = 8'h00; step = 1'b0; clr = 1'b0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Acquire: three correct steps lock
    samp(8'b10000000, 1'b1); chk_all("acq1", 1, 1, 0, 0, 0);
    samp(8'b11000000, 1'b1); chk_all("acq2", 2, 1, 0, 0, 0);
    samp(8'b11100000, 1'b1); chk_all("acq3", 3, 1, 1, 0, 0);

    // Walk to 15 and wrap to 0 while locked
    for (int i = 4; i < 16; i++) begin
      samp(jc[i], 1'b1);
      chk_all("walk", i, 1, 1, 0, 0);
    end
    samp(8'b00000000, 1'b1); chk_all("wrap", 0, 1, 1, 0, 0);

    // Sample enable low with garbage input: everything frozen
    for (int i = 0; i < 5; i++) begin
      idle((i % 2 == 0) ? 8'hA5 : 8'h3C);
      chk_all("freeze", 0, 1, 1, 0, 0);
    end

    // Skip a step while locked
    samp(jc[1], 1'b1); samp(jc[2], 1'b1); samp(jc[3], 1'b1);
    chk_all("at3", 3, 1, 1, 0, 0);
    samp(8'b11111000, 1'b1); chk_all("skip", 5, 1, 0, 1, 1);
    samp(8'b11111100, 1'b1); chk_all("relk1", 6, 1, 0, 0, 1);
    samp(8'b11111110, 1'b1); chk_all("relk2", 7, 1, 1, 0, 1);
    samp(8'b11111111, 1'b1); chk_all("relk3", 8, 1, 1, 0, 1);

    // Illegal pattern while locked
    samp(8'b10100000, 1'b1); chk_all("illegal", 8, 0, 0, 1, 2);
    samp(8'b01111111, 1'b1); chk_all("hunt1", 9, 1, 0, 0, 2);
    samp(8'b00111111, 1'b1); chk_all("hunt2", 10, 1, 0, 0, 2);
    samp(8'b00011111, 1'b1); chk_all("hunt3", 11, 1, 1, 0, 2);

    // Hold mode at index 4
    for (int i = 12; i <= 20; i++) samp(jc[i % 16], 1'b1);
    chk_all("at4", 4, 1, 1, 0, 2);
    for (int i = 0; i < 3; i++) begin
      samp(8'b11110000, 1'b0);
      chk_all("hold", 4, 1, 1, 0, 2);
    end
    samp(8'b11111000, 1'b0); chk_all("holderr", 5, 1, 0, 1, 3);
    chk("sat_cnt3", 32'(cnt_b), 32'd3);

    // Clear, then saturate the narrow counter
    @(negedge clk); sample_en = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_a", 32'(cnt_a), 32'd0);
    chk("clr_b", 32'(cnt_b), 32'd0);
    @(negedge clk); clr = 1'b0;
    p = 5;
    for (int k = 1; k <= 4; k++) begin
      samp(jc[(p + 1) % 16], 1'b1);
      samp(jc[(p + 2) % 16], 1'b1);
      chk("sat_lock", 32'(lock_a), 32'd1);
      samp(jc[(p + 4) % 16], 1'b1);
      chk("sat_err", 32'(err_a), 32'd1);
      chk("sat_cnt_a", 32'(cnt_a), 32'(k));
      chk("sat_cnt_b", 32'(cnt_b), 32'((k > 3) ? 3 : k));
      p = (p + 4) % 16;
    end

    // Clear coincident with a fifth error
    samp(jc[(p + 1) % 16], 1'b1);
    samp(jc[(p + 2) % 16], 1'b1);
    clr = 1'b1;
    samp(jc[(p + 4) % 16], 1'b1);
    chk("clrwin_err", 32'(err_a), 32'd1);
    chk("clrwin_a", 32'(cnt_a), 32'd0);
    chk("clrwin_b", 32'(cnt_b), 32'd0);
    @(negedge clk); clr = 1'b0;
    p = (p + 4) % 16;

    // One more error, then asynchronous reset mid-cycle
    samp(jc[(p + 1) % 16], 1'b1);
    samp(jc[(p + 2) % 16], 1'b1);
    samp(jc[(p + 4) % 16], 1'b1);
    chk("pre_rst_cnt", 32'(cnt_b), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst_b", 32'({idx_b, valid_b, lock_b, err_b, cnt_b}), 32'd0);
    @(negedge clk); rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
